// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and helpers for mem_port_arbiter and its grant selector.
//   Contents:
//     owner_t        which requester owns the in-flight transaction
//     state_t        arbiter FSM states
//     SZ_B/SZ_H/SZ_W LSB access size codes
//     STARVE_CNT_W   width of the optional fetch-starvation counter
//     FETCH_LEN      fixed fetch length (16-bit parcel, bytes-1)
//     size_to_len    size code -> engine length (bytes-1)
//     len_byte_mask  engine length -> mask of the valid read-data bytes
package mem_arb_pkg;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int STARVE_CNT_W = 3;

  localparam logic [1:0] FETCH_LEN = 2'd1;

  // Size code 11 is not a legal LSB size; it is handled as a word.
  function automatic logic [1:0] size_to_len(input logic [1:0] size);
    logic [1:0] len;
    case (size)
      SZ_B:    len = 2'd0;
      SZ_H:    len = 2'd1;
      SZ_W:    len = 2'd3;
      default: len = 2'd3;
    endcase
    return len;
  endfunction

  // Bytes above the transfer length are zeroed before data is returned.
  function automatic logic [31:0] len_byte_mask(input logic [1:0] len);
    logic [31:0] mask;
    case (len)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      2'd2:    mask = 32'h00FF_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_arb_grant_sel.sv
// mem_arb_grant_sel
//   Combinational winner pick for the memory port: LSB eligibility (UART
//   store gating), LSB-over-fetch priority and, when MEM_ARB_STARVE_EN is
//   defined, the fetch starvation override.
//   Ports:
//     f_req          in   fetch request
//     l_req          in   LSB request
//     l_we           in   LSB request is a store
//     l_addr         in   LSB address
//     io_buffer_full in   UART buffer full; holds stores to IO_ADDR
//     starve_cnt     in   consecutive LSB grants while fetch waited
//                         (MEM_ARB_STARVE_EN only)
//     grant_valid    out  some request may be granted
//     grant_owner    out  which request wins
//   Configuration macro: MEM_ARB_STARVE_EN
module mem_arb_grant_sel
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = 32'h30000
`ifdef MEM_ARB_STARVE_EN
  ,
  parameter int                STARVE_LIMIT = 4
`endif
) (
  input  logic              f_req,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic              io_buffer_full,
`ifdef MEM_ARB_STARVE_EN
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
  output logic              grant_valid,
  output owner_t            grant_owner
);

  logic l_eligible;
  logic fetch_forced;

  // A UART store is held while the IO buffer is full so fetch can proceed.
  // Once the starve limit is reached a waiting fetch is forced through.
  always_comb begin
    l_eligible = l_req && !(l_we && (l_addr == IO_ADDR) && io_buffer_full);
`ifdef MEM_ARB_STARVE_EN
    fetch_forced = f_req && (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT));
`else
    fetch_forced = 1'b0;
`endif
    grant_valid = l_eligible || f_req;
    grant_owner = (l_eligible && !fetch_forced) ? OWN_L : OWN_F;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-serial memory engine port between ICache refill (fetch)
//   and the LoadStoreBuffer. One winning request is latched, issued to the
//   engine with a one-cycle strobe, and its data and done pulse are returned
//   to the owner after the engine completes. Flushed work is cancelled: the
//   engine is never aborted, but the done pulse is suppressed.
//   Ports:
//     clk_in, rst_in      clock, synchronous active-high reset
//     rdy_in              low freezes every register and masks p_valid
//     clear_in            pipeline flush
//     io_buffer_full      UART buffer full (gates stores to IO_ADDR)
//     f_req/f_addr        fetch request; f_done/f_rdata fetch response
//     l_req/l_we/l_addr/l_size/l_wdata   LSB request
//     l_done/l_rdata      LSB response
//     p_valid/p_we/p_addr/p_len/p_wdata  engine issue
//     p_done/p_rdata      engine completion
//     busy                FSM not idle
//   Configuration macro: MEM_ARB_STARVE_EN (fetch starvation guard)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR      = 32'h30000,
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              io_buffer_full,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [1:0]        l_size,
  input  logic [31:0]       l_wdata,
  output logic              l_done,
  output logic [31:0]       l_rdata,
  output logic              p_valid,
  output logic              p_we,
  output logic [ADDR_W-1:0] p_addr,
  output logic [1:0]        p_len,
  output logic [31:0]       p_wdata,
  input  logic              p_done,
  input  logic [31:0]       p_rdata,
  output logic              busy
);

  state_t      state;
  owner_t      owner;
  logic        kill;
  logic        p_valid_q;
  logic        f_done_q;
  logic        l_done_q;
  logic        grant_valid;
  owner_t      grant_owner;
  logic [31:0] resp_data;
`ifdef MEM_ARB_STARVE_EN
  logic [STARVE_CNT_W-1:0] starve_cnt;
`endif

  mem_arb_grant_sel #(
    .ADDR_W      (ADDR_W),
    .IO_ADDR     (IO_ADDR)
`ifdef MEM_ARB_STARVE_EN
    ,
    .STARVE_LIMIT(STARVE_LIMIT)
`endif
  ) u_grant_sel (
    .f_req         (f_req),
    .l_req         (l_req),
    .l_we          (l_we),
    .l_addr        (l_addr),
    .io_buffer_full(io_buffer_full),
`ifdef MEM_ARB_STARVE_EN
    .starve_cnt    (starve_cnt),
`endif
    .grant_valid   (grant_valid),
    .grant_owner   (grant_owner)
  );

  assign resp_data = p_rdata & len_byte_mask(p_len);

  // Main FSM. Done pulses are computed on the BUSY->RESP edge so they are
  // visible in the RESP cycle, one cycle after p_done. A flush during BUSY
  // only marks the transaction killed; the engine must still finish it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      owner     <= OWN_F;
      kill      <= 1'b0;
      p_valid_q <= 1'b0;
      p_we      <= 1'b0;
      p_addr    <= '0;
      p_len     <= 2'd0;
      p_wdata   <= 32'd0;
      f_done_q  <= 1'b0;
      l_done_q  <= 1'b0;
      f_rdata   <= 32'd0;
      l_rdata   <= 32'd0;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt <= '0;
`endif
    end else if (rdy_in) begin
      p_valid_q <= 1'b0;
      f_done_q  <= 1'b0;
      l_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid && !clear_in) begin
            state     <= ISSUE;
            owner     <= grant_owner;
            p_valid_q <= 1'b1;
            if (grant_owner == OWN_L) begin
              p_we    <= l_we;
              p_addr  <= l_addr;
              p_len   <= size_to_len(l_size);
              p_wdata <= l_wdata;
            end else begin
              p_we    <= 1'b0;
              p_addr  <= f_addr;
              p_len   <= FETCH_LEN;
              p_wdata <= 32'd0;
            end
`ifdef MEM_ARB_STARVE_EN
            if (grant_owner == OWN_F) begin
              starve_cnt <= '0;
            end else if (f_req && (starve_cnt != '1)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
`endif
          end
        end
        ISSUE: begin
          state <= clear_in ? IDLE : BUSY;
        end
        BUSY: begin
          if (clear_in) begin
            kill <= 1'b1;
          end
          if (p_done) begin
            state <= RESP;
            if (!kill && !clear_in) begin
              if (owner == OWN_L) begin
                l_rdata  <= resp_data;
                l_done_q <= 1'b1;
              end else begin
                f_rdata  <= resp_data;
                f_done_q <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The strobe and done pulses are masked while frozen so a stalled cycle
  // never repeats them, and a flush arriving in ISSUE or RESP cancels them
  // in the same cycle.
  assign p_valid = p_valid_q & rdy_in & ~clear_in;
  assign f_done  = f_done_q & rdy_in & ~clear_in;
  assign l_done  = l_done_q & rdy_in & ~clear_in;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a table of transactions with
//   hand-computed expectations, directed multi-cycle corner cases (flush,
//   freeze, reset) and random transactions checked against a rule-level
//   model of the arbiter.
module tb_mem_port_arbiter;

  localparam logic [31:0] IO_ADDR = 32'h30000;

  typedef struct {
    logic        f_req;
    logic        l_req;
    logic        l_we;
    logic        io_full;
    logic [31:0] f_addr;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic [31:0] l_wdata;
    logic [31:0] rdata;
    logic        hold_f;
    logic        exp_grant;
    logic        exp_l;
    logic [1:0]  exp_len;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = 32'd0;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0;
  logic        l_we = 1'b0;
  logic [31:0] l_addr = 32'd0;
  logic [1:0]  l_size = 2'd0;
  logic [31:0] l_wdata = 32'd0;
  logic        l_done;
  logic [31:0] l_rdata;
  logic        p_valid;
  logic        p_we;
  logic [31:0] p_addr;
  logic [1:0]  p_len;
  logic [31:0] p_wdata;
  logic        p_done = 1'b0;
  logic [31:0] p_rdata = 32'd0;
  logic        busy;

  int checks = 0;
  int failures = 0;
`ifdef MEM_ARB_STARVE_EN
  int streak = 0;
`endif

  vec_t tbl[9];

  mem_port_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_in      (clear_in),
    .io_buffer_full(io_buffer_full),
    .f_req         (f_req),
    .f_addr        (f_addr),
    .f_done        (f_done),
    .f_rdata       (f_rdata),
    .l_req         (l_req),
    .l_we          (l_we),
    .l_addr        (l_addr),
    .l_size        (l_size),
    .l_wdata       (l_wdata),
    .l_done        (l_done),
    .l_rdata       (l_rdata),
    .p_valid       (p_valid),
    .p_we          (p_we),
    .p_addr        (p_addr),
    .p_len         (p_len),
    .p_wdata       (p_wdata),
    .p_done        (p_done),
    .p_rdata       (p_rdata),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    f_req          = v.f_req;
    f_addr         = v.f_addr;
    l_req          = v.l_req;
    l_we           = v.l_we;
    l_addr         = v.l_addr;
    l_size         = v.l_size;
    l_wdata        = v.l_wdata;
    io_buffer_full = v.io_full;
  endtask

  function automatic vec_t mkVec(input logic fr, input logic lr, input logic lwe, input logic iof,
                                 input logic [31:0] fa, input logic [31:0] la, input logic [1:0] ls,
                                 input logic [31:0] wd, input logic [31:0] rd, input logic hf,
                                 input logic eg, input logic el, input logic [1:0] elen,
                                 input logic [31:0] erd);
    vec_t v;
    v.f_req = fr; v.l_req = lr; v.l_we = lwe; v.io_full = iof;
    v.f_addr = fa; v.l_addr = la; v.l_size = ls; v.l_wdata = wd;
    v.rdata = rd; v.hold_f = hf;
    v.exp_grant = eg; v.exp_l = el; v.exp_len = elen; v.exp_rdata = erd;
    return v;
  endfunction

  // Rule-level reference: who wins, how many bytes move, what comes back.
  function automatic vec_t modelExpect(input vec_t v);
    vec_t r;
    logic l_ok;
    logic forced;
    int nbytes;
    longint keep;
    r = v;
    l_ok = v.l_req && !(v.l_we && v.l_addr == IO_ADDR && v.io_full);
    forced = 1'b0;
`ifdef MEM_ARB_STARVE_EN
    forced = v.f_req && (streak >= 4);
`endif
    r.exp_grant = l_ok || v.f_req;
    r.exp_l = l_ok && !forced;
    if (r.exp_l) nbytes = (v.l_size == 2'd0) ? 1 : (v.l_size == 2'd1) ? 2 : 4;
    else nbytes = 2;
    r.exp_len = 2'(nbytes - 1);
    keep = (64'd1 << (8 * nbytes)) - 64'd1;
    r.exp_rdata = v.rdata & keep[31:0];
    return r;
  endfunction

  task automatic doReset();
    rst_in = 1'b1;
    clear_in = 1'b0;
    rdy_in = 1'b1;
    f_req = 1'b0;
    l_req = 1'b0;
    p_done = 1'b0;
    io_buffer_full = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
`ifdef MEM_ARB_STARVE_EN
    streak = 0;
`endif
  endtask

  // One complete transaction, entered and left at a negedge with the DUT idle.
  task automatic runTxn(input vec_t v, input int delay);
    applyStimulus(v);
    @(negedge clk_in);
    if (!v.exp_grant) begin
      checkOutput("nogrant_pvalid", 32'(p_valid), 32'd0);
      checkOutput("nogrant_busy", 32'(busy), 32'd0);
      @(negedge clk_in);
      checkOutput("nogrant_busy2", 32'(busy), 32'd0);
      f_req = 1'b0;
      l_req = 1'b0;
    end else begin
`ifdef MEM_ARB_STARVE_EN
      if (!v.exp_l) streak = 0;
      else if (v.f_req && streak < 7) streak++;
`endif
      checkOutput("issue_pvalid", 32'(p_valid), 32'd1);
      checkOutput("issue_pwe", 32'(p_we), v.exp_l ? 32'(v.l_we) : 32'd0);
      checkOutput("issue_paddr", p_addr, v.exp_l ? v.l_addr : v.f_addr);
      checkOutput("issue_plen", 32'(p_len), 32'(v.exp_len));
      checkOutput("issue_pwdata", p_wdata, v.exp_l ? v.l_wdata : 32'd0);
      @(negedge clk_in);
      checkOutput("busy_pvalid", 32'(p_valid), 32'd0);
      for (int i = 0; i < delay; i++) begin
        checkOutput("early_done", 32'(f_done | l_done), 32'd0);
        @(negedge clk_in);
      end
      p_done = 1'b1;
      p_rdata = v.rdata;
      @(negedge clk_in);
      p_done = 1'b0;
      checkOutput("resp_fdone", 32'(f_done), v.exp_l ? 32'd0 : 32'd1);
      checkOutput("resp_ldone", 32'(l_done), v.exp_l ? 32'd1 : 32'd0);
      checkOutput("resp_rdata", v.exp_l ? l_rdata : f_rdata, v.exp_rdata);
      l_req = 1'b0;
      if (!v.hold_f) f_req = 1'b0;
      @(negedge clk_in);
      checkOutput("after_done", 32'(f_done | l_done), 32'd0);
      checkOutput("after_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t v;

    // Table of transactions with expectations worked out by hand.
    tbl[0] = mkVec(1, 1, 0, 0, 32'h2000, 32'h100,  2'b10, 32'h0,  32'hDEADBEEF, 1, 1, 1, 2'd3, 32'hDEADBEEF);
    tbl[1] = mkVec(1, 0, 0, 0, 32'h2000, 32'h0,    2'b00, 32'h0,  32'h12345678, 0, 1, 0, 2'd1, 32'h00005678);
    tbl[2] = mkVec(1, 1, 1, 1, 32'h2004, IO_ADDR,  2'b00, 32'h41, 32'hAABBCCDD, 0, 1, 0, 2'd1, 32'h0000CCDD);
    tbl[3] = mkVec(0, 1, 1, 0, 32'h2004, IO_ADDR,  2'b00, 32'h41, 32'h99887766, 0, 1, 1, 2'd0, 32'h00000066);
    tbl[4] = mkVec(0, 1, 0, 0, 32'h0,    32'h104,  2'b01, 32'h0,  32'hAABBCCDD, 0, 1, 1, 2'd1, 32'h0000CCDD);
    tbl[5] = mkVec(0, 1, 0, 0, 32'h0,    32'h108,  2'b11, 32'h0,  32'hCAFEF00D, 0, 1, 1, 2'd3, 32'hCAFEF00D);
    tbl[6] = mkVec(0, 1, 1, 1, 32'h0,    IO_ADDR,  2'b00, 32'h42, 32'h0,        0, 0, 0, 2'd0, 32'h0);
    tbl[7] = mkVec(1, 1, 1, 1, 32'h3000, 32'h200,  2'b01, 32'h5A5A, 32'h01020304, 0, 1, 1, 2'd1, 32'h00000304);
    tbl[8] = mkVec(0, 1, 0, 1, 32'h0,    IO_ADDR,  2'b00, 32'h0,  32'h000000F7, 0, 1, 1, 2'd0, 32'h000000F7);

    doReset();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pvalid", 32'(p_valid), 32'd0);
    checkOutput("rst_done", 32'(f_done | l_done), 32'd0);
    checkOutput("rst_paddr", p_addr, 32'd0);
    checkOutput("rst_rdata", f_rdata | l_rdata, 32'd0);

    for (int i = 0; i < 9; i++) runTxn(tbl[i], i % 3);

    // Flush while IDLE blocks the grant; flush in ISSUE cancels the strobe.
    v = mkVec(1, 0, 0, 0, 32'h4000, 32'h0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 2'd1, 32'h0);
    applyStimulus(v);
    clear_in = 1'b1;
    @(negedge clk_in);
    checkOutput("clr_idle_busy", 32'(busy), 32'd0);
    clear_in = 1'b0;
    @(negedge clk_in);
    checkOutput("clr_idle_then_grant", 32'(p_valid), 32'd1);
    clear_in = 1'b1;
    #1;
    checkOutput("clr_issue_pvalid", 32'(p_valid), 32'd0);
    @(negedge clk_in);
    clear_in = 1'b0;
    f_req = 1'b0;
    checkOutput("clr_issue_idle", 32'(busy), 32'd0);
    @(negedge clk_in);

    // Flush while BUSY: engine completes, no done, back to IDLE after RESP.
    applyStimulus(v);
    repeat (2) @(negedge clk_in);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    f_req = 1'b0;
    p_done = 1'b1;
    p_rdata = 32'h77778888;
    @(negedge clk_in);
    p_done = 1'b0;
    checkOutput("kill_fdone", 32'(f_done), 32'd0);
    @(negedge clk_in);
    checkOutput("kill_idle", 32'(busy), 32'd0);
    checkOutput("kill_fdone2", 32'(f_done), 32'd0);

    // Freeze during BUSY: a p_done seen while rdy_in is low is not taken.
    applyStimulus(v);
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    p_done = 1'b1;
    p_rdata = 32'h11112222;
    @(negedge clk_in);
    checkOutput("frz_busy", 32'(busy), 32'd1);
    checkOutput("frz_fdone", 32'(f_done), 32'd0);
    p_done = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk_in);
    checkOutput("frz_still_busy", 32'(busy), 32'd1);
    checkOutput("frz_fdone2", 32'(f_done), 32'd0);
    p_done = 1'b1;
    @(negedge clk_in);
    p_done = 1'b0;
    checkOutput("frz_resume_fdone", 32'(f_done), 32'd1);
    checkOutput("frz_resume_rdata", f_rdata, 32'h00002222);
    f_req = 1'b0;
    @(negedge clk_in);
    checkOutput("frz_idle", 32'(busy), 32'd0);

    // Reset in the ISSUE cycle clears everything on the next edge.
    applyStimulus(tbl[0]);
    @(negedge clk_in);
    checkOutput("rstmid_pvalid_before", 32'(p_valid), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    f_req = 1'b0;
    l_req = 1'b0;
    checkOutput("rstmid_pvalid", 32'(p_valid), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_paddr", p_addr, 32'd0);
    checkOutput("rstmid_plen", 32'(p_len), 32'd0);
    checkOutput("rstmid_rdata", f_rdata | l_rdata, 32'd0);
    checkOutput("rstmid_done", 32'(f_done | l_done), 32'd0);
    @(negedge clk_in);

    // Continuous LSB loads with fetch waiting.
    doReset();
    for (int i = 0; i < 6; i++) begin
      v = mkVec(1, 1, 0, 0, 32'h5000, 32'h300 + 32'(4 * i), 2'b10, 32'h0, $urandom, 0, 0, 0, 2'd0, 32'h0);
      v = modelExpect(v);
`ifndef MEM_ARB_STARVE_EN
      checkOutput("strict_prio_model", 32'(v.exp_l), 32'd1);
`endif
      runTxn(v, 0);
    end

    // Random transactions against the rule-level model.
    for (int i = 0; i < 40; i++) begin
      v.f_req   = 1'($urandom_range(0, 1));
      v.l_req   = 1'($urandom_range(0, 1));
      v.l_we    = 1'($urandom_range(0, 1));
      v.io_full = 1'($urandom_range(0, 1));
      v.f_addr  = $urandom & 32'hFFFF_FFFE;
      v.l_addr  = ($urandom_range(0, 2) == 0) ? IO_ADDR : $urandom;
      v.l_size  = 2'($urandom_range(0, 3));
      v.l_wdata = $urandom;
      v.rdata   = $urandom;
      v.hold_f  = 1'b0;
      v = modelExpect(v);
      runTxn(v, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
